// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Requester side of the instruction-memory interface. Owns the fetch PC,
// drives the word address to a combinational instruction ROM, captures the
// returned word and buffers {pc, inst} pairs in a small FIFO for decode.
// Branch/jump redirects flush the buffer and restart fetch at the target.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_addr       out  byte address to instruction memory (== fetch_pc)
//   imem_inst       in   instruction word for imem_addr, same cycle
//   redirect_valid  in   one-cycle pulse: flush and restart at redirect_target
//   redirect_target in   new fetch address (bits [1:0] forced to 0)
//   if_valid        out  head entry valid for decode
//   if_inst         out  head entry instruction word (0 when empty)
//   if_pc           out  head entry PC (0 when empty)
//   if_pc_plus4     out  head entry PC + 4 (0 when empty)
//   id_ready        in   decode accepts the head entry this cycle
//
// Handshake: an entry moves to decode on a rising edge where if_valid and
// id_ready are both high and redirect_valid is low. if_valid never depends
// combinationally on id_ready; once raised it stays up with stable data
// until the entry is accepted or a redirect/reset flushes it.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_buf   [FIFO_DEPTH];
    logic [31:0]   inst_buf [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;

    // Indices wrap modulo FIFO_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PW'(1);
    endfunction

    // Redirect suppresses both sides: a same-cycle id_ready is not a transfer.
    // A full FIFO may still accept a push when the head leaves in the same
    // cycle, which keeps streaming bubble-free.
    assign pop  = if_valid && id_ready && !redirect_valid;
    assign push = !redirect_valid && ((count < DEPTH_C) || pop);

    assign imem_addr   = fetch_pc;
    assign if_valid    = (count != '0);
    assign if_inst     = if_valid ? inst_buf[head]         : 32'h0;
    assign if_pc       = if_valid ? pc_buf[head]           : 32'h0;
    assign if_pc_plus4 = if_valid ? pc_buf[head] + 32'd4   : 32'h0;

    // Entry storage needs no reset: outputs are gated by count, and reset
    // clears count, so no stale entry is ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[tail]   <= fetch_pc;
            inst_buf[tail] <= imem_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= {PC_RESET[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_target[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            // On a stall fetch_pc holds, so the same word is re-read.
            if (push) begin
                tail     <= next_idx(tail);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= next_idx(head);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
